// File: rtl/dbscan_pkg.sv
// dbscan_pkg
// Shared definitions for the DBSCAN point-store blocks:
//   DEF_ADDR_W / DEF_COORD_W / DEF_LABEL_W : default widths
//   NOISE_LABEL                            : label value meaning "noise"
//   point_t                                : point record (x, y, z, label, last)
//   state_t                                : read-out engine FSM states
package dbscan_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_COORD_W = 8;
  localparam int DEF_LABEL_W = 8;

  localparam logic [DEF_LABEL_W-1:0] NOISE_LABEL = '0;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COORD_W-1:0] z;
    logic [DEF_LABEL_W-1:0] label;
    logic                   last;
  } point_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2
// Two-entry first-word-fall-through FIFO of point records.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or when full and popping)
//   push_data  : record to store
//   pop        : remove the head entry (ignored when empty)
//   head       : current head record, valid whenever !empty
//   full/empty : occupancy flags
module stream_fifo2
  import dbscan_pkg::*;
#(
  parameter type rec_t = point_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty
);

  rec_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  assign head  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cluster_result_streamer.sv
// cluster_result_streamer
// Walks point memory from address 0 to num_points-1 after clustering and
// streams every point with its cluster label over a valid/ready interface.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start, num_points         : begin a scan of num_points points (IDLE only)
//   rd_en, rd_addr            : point memory read port (1-cycle latency)
//   rd_x/rd_y/rd_z/rd_label   : read data, valid the cycle after rd_en
//   out_x/out_y/out_z/out_label, out_valid, out_last, out_ready : output stream
//   busy                      : scan in progress (any state but IDLE)
//   finished                  : one-cycle pulse at scan completion
// Configuration macro: NOISE_SKIP_EN -- when defined, label-0 (noise) points
// are dropped and out_last marks the last emitted non-noise point.
module cluster_result_streamer
  import dbscan_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COORD_W = DEF_COORD_W,
  parameter int LABEL_W = DEF_LABEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    num_points,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  input  logic [COORD_W-1:0] rd_z,
  input  logic [LABEL_W-1:0] rd_label,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [COORD_W-1:0] out_z,
  output logic [LABEL_W-1:0] out_label,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               finished
);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [LABEL_W-1:0] label;
    logic               last;
  } rec_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] num_q;
  logic [ADDR_W:0] addr_q;
  logic [ADDR_W:0] last_addr;
  logic            inflight_q;
  logic            rd_last_q;
  logic            zero_hold_q;

  rec_t            rd_rec;
  rec_t            push_rec;
  rec_t            fifo_head;
  logic            fifo_push;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic [2:0]      occ_now;
  logic [2:0]      occ_after;
  logic            issue_ok;
  logic            buf_clear;
  logic            drain_done;

  assign last_addr = num_q - ONE;
  assign rd_rec    = '{x: rd_x, y: rd_y, z: rd_z, label: rd_label, last: 1'b0};

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_x     = fifo_head.x;
  assign out_y     = fifo_head.y;
  assign out_z     = fifo_head.z;
  assign out_label = fifo_head.label;
  assign out_last  = fifo_head.last;

  // Occupancy after this cycle's pop plus the read already in flight; a new
  // read may only be issued if that leaves room, which keeps 1 beat/cycle
  // under ready-high without ever overflowing the 2-entry buffer.
  assign occ_now   = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
  assign occ_after = occ_now - {2'b00, pop} + {2'b00, inflight_q};
  assign issue_ok  = (occ_after < 3'd2);
  assign buf_clear = fifo_empty || (!fifo_full && pop);

`ifdef NOISE_SKIP_EN
  // One non-noise beat is held back so its last flag can be decided once the
  // next non-noise beat arrives or the final read has returned.
  rec_t hold_q;
  logic hold_valid_q;
  logic flush_q;
  logic qual;
  logic flush_push;

  assign qual       = inflight_q && (rd_label != LABEL_W'(NOISE_LABEL));
  assign flush_push = flush_q && hold_valid_q && !fifo_full;
  assign drain_done = !inflight_q && buf_clear && !hold_valid_q && !flush_q;

  always_comb begin
    fifo_push = 1'b0;
    push_rec  = hold_q;
    if (qual && hold_valid_q) begin
      fifo_push = 1'b1;
    end else if (flush_push) begin
      fifo_push     = 1'b1;
      push_rec.last = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      if (qual) begin
        hold_q       <= rd_rec;
        hold_valid_q <= 1'b1;
      end else if (flush_push) begin
        hold_valid_q <= 1'b0;
      end
      if (inflight_q && rd_last_q)
        flush_q <= 1'b1;
      else if (flush_q && (!hold_valid_q || flush_push))
        flush_q <= 1'b0;
    end
  end
`else
  assign drain_done = !inflight_q && buf_clear;

  always_comb begin
    fifo_push     = inflight_q;
    push_rec      = rd_rec;
    push_rec.last = rd_last_q;
  end
`endif

  stream_fifo2 #(.rec_t(rec_t)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An empty scan lingers one extra cycle in FINISH (zero_hold_q) so its
  // finished pulse lands where the first read would have returned.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    finished = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_points == '0) ? ST_FINISH : ST_READ;
      end
      ST_READ: begin
        if ((addr_q < num_q) && issue_ok) begin
          rd_en = 1'b1;
          if (addr_q == last_addr) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (!zero_hold_q) begin
          finished = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr = rd_en ? addr_q[ADDR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_q       <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      zero_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      rd_last_q  <= rd_en && (addr_q == last_addr);
      if ((state_q == ST_IDLE) && start) begin
        num_q       <= num_points;
        addr_q      <= '0;
        zero_hold_q <= (num_points == '0);
      end else if (rd_en) begin
        addr_q <= addr_q + ONE;
      end
      if (state_q == ST_FINISH) zero_hold_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cluster_result_streamer.sv
// tb_cluster_result_streamer
// Self-checking bench for cluster_result_streamer: table-driven scans plus
// randomized scans, checked against a queue-based model of the expected beat
// stream. Hand-written sequences cover restart-during-scan and mid-scan reset.
module tb_cluster_result_streamer;

  localparam int ADDR_W  = 6;
  localparam int COORD_W = 8;
  localparam int LABEL_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W:0]    num_points;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COORD_W-1:0] rd_x, rd_y, rd_z;
  logic [LABEL_W-1:0] rd_label;
  logic [COORD_W-1:0] out_x, out_y, out_z;
  logic [LABEL_W-1:0] out_label;
  logic               out_valid, out_last, out_ready;
  logic               busy, finished;

  always #5 clk = ~clk;

  cluster_result_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_points (num_points),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_z       (rd_z),
    .rd_label   (rd_label),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_z      (out_z),
    .out_label  (out_label),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .finished   (finished)
  );

  typedef struct {
    int n;
    int ready_mode;
    int fill;
    int fin_lat;
  } vec_t;

  typedef struct {
    logic [7:0] x, y, z, label;
    logic       last;
    int         cyc;
  } beat_t;

  logic [7:0] mem_x [64];
  logic [7:0] mem_y [64];
  logic [7:0] mem_z [64];
  logic [7:0] mem_l [64];

  beat_t got_q[$];
  beat_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int reads = 0;
  int fin_count = 0;
  int fin_cyc = -1;
  int valid_cycles = 0;
  int ready_mode = 0;
  int t0 = 0;
  logic        stall_prev = 1'b0;
  logic [32:0] prev_bits = '0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Point memory with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_x     <= mem_x[rd_addr];
      rd_y     <= mem_y[rd_addr];
      rd_z     <= mem_z[rd_addr];
      rd_label <= mem_l[rd_addr];
    end
  end

  // Sink readiness: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom);
      endcase
    end
  end

  // Monitor: read addresses, beat capture, stall stability, finished pulses.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_en) begin
        checkOutput("rd_addr", rd_addr, reads);
        reads++;
      end
      if (stall_prev) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", {out_x, out_y, out_z, out_label, out_last}, prev_bits);
      end
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready)
        got_q.push_back('{x: out_x, y: out_y, z: out_z, label: out_label, last: out_last, cyc: cyc});
      if (finished) begin
        fin_count++;
        fin_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      prev_bits  = {out_x, out_y, out_z, out_label, out_last};
    end
  end

  task automatic fillMemory(input int fill);
    logic [7:0] ex [5] = '{8'd10, 8'd11, 8'd12, 8'd8,  8'd9};
    logic [7:0] ey [5] = '{8'd10, 8'd12, 8'd13, 8'd11, 8'd14};
    logic [7:0] ez [5] = '{8'd10, 8'd9,  8'd11, 8'd7,  8'd8};
    logic [7:0] nl [5] = '{8'd1,  8'd0,  8'd2,  8'd0,  8'd0};
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = 8'($urandom);
      mem_y[i] = 8'($urandom);
      mem_z[i] = 8'($urandom);
      mem_l[i] = 8'($urandom_range(0, 3));
      if (fill == 3) mem_l[i] = 8'd0;
    end
    for (int i = 0; i < 5; i++) begin
      if (fill == 0) begin
        mem_x[i] = ex[i];
        mem_y[i] = ey[i];
        mem_z[i] = ez[i];
        mem_l[i] = 8'd1;
      end else if (fill == 2) begin
        mem_l[i] = nl[i];
      end
    end
  endtask

  // Reference: points in address order (noise dropped when the skip feature
  // is built in), with last set on the final emitted point.
  task automatic buildExpected(input int n);
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
`ifdef NOISE_SKIP_EN
      if (mem_l[i] == 8'd0) continue;
`endif
      exp_q.push_back('{x: mem_x[i], y: mem_y[i], z: mem_z[i], label: mem_l[i], last: 1'b0, cyc: 0});
    end
    if (exp_q.size() > 0) begin
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic applyStimulus(input int n, input int rmode, input int fill, input bit restart);
    fillMemory(fill);
    buildExpected(n);
    @(posedge clk);
    #1;
    ready_mode = rmode;
    got_q.delete();
    reads = 0;
    fin_count = 0;
    fin_cyc = -1;
    valid_cycles = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    num_points = 7'(n);
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_points = 7'($urandom);
    checkOutput("busy_after_start", busy, 1);
    if (restart) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      num_points = 7'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 600 && fin_count == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verifyScan(input int n, input int lat);
    int m;
    checkOutput("finished_count", fin_count, 1);
    checkOutput("read_count", reads, n);
    checkOutput("beat_count", got_q.size(), exp_q.size());
    checkOutput("busy_idle", busy, 0);
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checkOutput("beat_x", got_q[i].x, exp_q[i].x);
      checkOutput("beat_y", got_q[i].y, exp_q[i].y);
      checkOutput("beat_z", got_q[i].z, exp_q[i].z);
      checkOutput("beat_label", got_q[i].label, exp_q[i].label);
      checkOutput("beat_last", got_q[i].last, exp_q[i].last);
    end
    if (exp_q.size() == 0) checkOutput("valid_cycles", valid_cycles, 0);
`ifndef NOISE_SKIP_EN
    if (lat >= 0) begin
      checkOutput("finished_cycle", fin_cyc - t0, lat);
      if (got_q.size() > 0) begin
        checkOutput("first_beat_cycle", got_q[0].cyc - t0, 3);
        checkOutput("last_beat_cycle", got_q[got_q.size()-1].cyc - t0, n + 2);
      end
    end
`endif
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{n: 5,  ready_mode: 0, fill: 0, fin_lat: 8};
    tbl[1] = '{n: 45, ready_mode: 1, fill: 1, fin_lat: -1};
    tbl[2] = '{n: 0,  ready_mode: 0, fill: 1, fin_lat: 2};
    tbl[3] = '{n: 1,  ready_mode: 0, fill: 1, fin_lat: 4};
    tbl[4] = '{n: 64, ready_mode: 0, fill: 1, fin_lat: 67};
    tbl[5] = '{n: 5,  ready_mode: 0, fill: 2, fin_lat: 8};
    tbl[6] = '{n: 5,  ready_mode: 0, fill: 3, fin_lat: 8};
    tbl[7] = '{n: 30, ready_mode: 2, fill: 1, fin_lat: -1};
    tbl[8] = '{n: 64, ready_mode: 2, fill: 1, fin_lat: -1};

    rst = 1'b1;
    start = 1'b0;
    num_points = '0;
    rd_x = '0;
    rd_y = '0;
    rd_z = '0;
    rd_label = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_en", rd_en, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_finished", finished, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_out_data", {out_x, out_y, out_z, out_label}, 0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(tbl[v].n, tbl[v].ready_mode, tbl[v].fill, 1'b0);
      verifyScan(tbl[v].n, tbl[v].fin_lat);
    end

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 64);
      applyStimulus(n, 2, 1, 1'b0);
      verifyScan(n, -1);
    end

    $display("[TB] start pulsed during READ");
    applyStimulus(20, 0, 1, 1'b1);
    verifyScan(20, 23);

    $display("[TB] reset after 3 beats of a 10-point scan");
    fillMemory(1);
    @(posedge clk);
    #1;
    ready_mode = 0;
    got_q.delete();
    reads = 0;
    fin_count = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    num_points = 7'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 50 && got_q.size() < 3; i++) @(negedge clk);
    checkOutput("beats_before_reset", got_q.size(), 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_data", {out_x, out_y, out_z, out_label}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_finished", finished, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_finished_after_reset", fin_count, 0);
    applyStimulus(10, 0, 1, 1'b0);
    verifyScan(10, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
